// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - register word offsets and AHB transfer encodings for the board I/O responder
package board_io_pkg;

    localparam logic [2:0] REG_LEDR     = 3'd0;
    localparam logic [2:0] REG_LEDG     = 3'd1;
    localparam logic [2:0] REG_HEX      = 3'd2;
    localparam logic [2:0] REG_SW       = 3'd3;
    localparam logic [2:0] REG_KEY      = 3'd4;
    localparam logic [2:0] REG_KEY_EDGE = 3'd5;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/board_io_debounce.sv
// rtl/board_io_debounce.sv - 2-flop synchroniser with optional per-bit debounce counter (BOARD_IO_DEBOUNCE_EN)
module board_io_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 2,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    // Inverting instances reset their flops to the raw idle level so the accepted value starts at 0.
    localparam logic [WIDTH-1:0] SYNC_INIT = INVERT ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    if (CYCLES < 2) begin : g_cycles_check
        $error("board_io_debounce: CYCLES must be at least 2");
    end

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= SYNC_INIT;
            sync2 <= SYNC_INIT;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign sync_val = INVERT ? ~sync2 : sync2;

`ifdef BOARD_IO_DEBOUNCE_EN
    localparam int CW = $clog2(CYCLES);

    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_val[i] == acc[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(CYCLES - 1)) begin
                    acc[i] <= sync_val[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stable = acc;
`else
    assign stable = sync_val;
`endif

endmodule

// File: rtl/ahb_lite_board_io.sv
// rtl/ahb_lite_board_io.sv - zero-wait AHB-Lite responder for board LEDs, HEX, switches and keys (BOARD_IO_DEBOUNCE_EN)
module ahb_lite_board_io
    import board_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    input  logic [N_SW-1:0]  SW_IN,
    input  logic [N_KEY-1:0] KEY_N_IN,
    output logic [17:0]      LEDR_OUT,
    output logic [8:0]       LEDG_OUT,
    output logic [23:0]      HEX_OUT
);

    logic             dp_valid;
    logic [2:0]       dp_addr;
    logic             dp_write;
    logic             wr;
    logic [17:0]      ledr;
    logic [8:0]       ledg;
    logic [23:0]      hex;
    logic [N_SW-1:0]  sw_acc;
    logic [N_KEY-1:0] key_acc;
    logic [N_KEY-1:0] key_prev;
    logic [N_KEY-1:0] key_edge;
    logic [N_KEY-1:0] key_clr;
    logic             unused_bits;

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign unused_bits = &{1'b0, HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:24]};

    board_io_debounce #(.WIDTH(N_SW), .CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b0)) u_sw (
        .clk    (HCLK),
        .rst    (HRESET),
        .raw    (SW_IN),
        .stable (sw_acc)
    );

    board_io_debounce #(.WIDTH(N_KEY), .CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_key (
        .clk    (HCLK),
        .rst    (HRESET),
        .raw    (KEY_N_IN),
        .stable (key_acc)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_addr  <= '0;
            dp_write <= 1'b0;
        end else begin
            dp_valid <= HSEL & HTRANS[1] & HREADY;
            if (HSEL & HTRANS[1] & HREADY) begin
                dp_addr  <= HADDR[4:2];
                dp_write <= HWRITE;
            end
        end
    end

    assign wr      = dp_valid & dp_write;
    assign key_clr = (wr && dp_addr == REG_KEY_EDGE) ? HWDATA[N_KEY-1:0] : '0;

    // A new edge is OR-ed in after the clear so a coincident W1C cannot drop it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ledr     <= '0;
            ledg     <= '0;
            hex      <= '0;
            key_prev <= '0;
            key_edge <= '0;
        end else begin
            if (wr && dp_addr == REG_LEDR) ledr <= HWDATA[17:0];
            if (wr && dp_addr == REG_LEDG) ledg <= HWDATA[8:0];
            if (wr && dp_addr == REG_HEX)  hex  <= HWDATA[23:0];
            key_prev <= key_acc;
            key_edge <= (key_edge & ~key_clr) | (key_acc & ~key_prev);
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_valid) begin
            case (dp_addr)
                REG_LEDR:     HRDATA[17:0]      = ledr;
                REG_LEDG:     HRDATA[8:0]       = ledg;
                REG_HEX:      HRDATA[23:0]      = hex;
                REG_SW:       HRDATA[N_SW-1:0]  = sw_acc;
                REG_KEY:      HRDATA[N_KEY-1:0] = key_acc;
                REG_KEY_EDGE: HRDATA[N_KEY-1:0] = key_edge;
                default:      HRDATA            = '0;
            endcase
        end
    end

    assign LEDR_OUT = ledr;
    assign LEDG_OUT = ledg;
    assign HEX_OUT  = hex;

endmodule

// File: tb/tb_ahb_lite_board_io.sv
// tb/tb_ahb_lite_board_io.sv - directed self-checking bench for ahb_lite_board_io (BOARD_IO_DEBOUNCE_EN aware)
module tb_ahb_lite_board_io;
    import board_io_pkg::*;

    localparam int DC = 8;
`ifdef BOARD_IO_DEBOUNCE_EN
    localparam int LAT = 3 + DC;
`else
    localparam int LAT = 3;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [9:0]  SW_IN;
    logic [3:0]  KEY_N_IN;
    logic [17:0] LEDR_OUT;
    logic [8:0]  LEDG_OUT;
    logic [23:0] HEX_OUT;

    int passed = 0;
    int total  = 0;

    ahb_lite_board_io #(.DEBOUNCE_CYCLES(DC), .N_SW(10), .N_KEY(4)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .SW_IN     (SW_IN),
        .KEY_N_IN  (KEY_N_IN),
        .LEDR_OUT  (LEDR_OUT),
        .LEDG_OUT  (LEDG_OUT),
        .HEX_OUT   (HEX_OUT)
    );

    always #5 HCLK = ~HCLK;

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge HCLK);
        total++; if (LEDR_OUT !== 18'h0 || LEDG_OUT !== 9'h0 || HEX_OUT !== 24'h0)
            $display("FAIL reset_outputs: got ledr=%h ledg=%h hex=%h want all 0", LEDR_OUT, LEDG_OUT, HEX_OUT);
        else passed++;
        total++; if (HRDATA !== 32'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0)
            $display("FAIL reset_bus: got hrdata=%h hreadyout=%b hresp=%b want 0/1/0", HRDATA, HREADYOUT, HRESP);
        else passed++;
        @(posedge HCLK); #1;
        ahb_read(32'h10, d);
        total++; if (d !== 32'h0) $display("FAIL reset_key: got %h want 0", d); else passed++;
        ahb_read(32'h14, d);
        total++; if (d !== 32'h0) $display("FAIL reset_key_edge: got %h want 0", d); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h00;
        @(posedge HCLK); #1;
        HWDATA = 32'h0003_FFFF; HWRITE = 1'b0; HADDR = 32'h00;
        @(negedge HCLK);
        total++; if (HREADYOUT !== 1'b1) $display("FAIL b2b_hreadyout_wr: got %b want 1", HREADYOUT); else passed++;
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        total++; if (HRDATA !== 32'h0003_FFFF) $display("FAIL b2b_hrdata: got %h want 0003ffff", HRDATA); else passed++;
        total++; if (LEDR_OUT !== 18'h3FFFF) $display("FAIL b2b_ledr: got %h want 3ffff", LEDR_OUT); else passed++;
        total++; if (HREADYOUT !== 1'b1) $display("FAIL b2b_hreadyout_rd: got %b want 1", HREADYOUT); else passed++;
        @(posedge HCLK); #1;
        ahb_write(32'h04, 32'hFFFF_FFFF);
        ahb_read(32'h04, d);
        total++; if (d !== 32'h0000_01FF || LEDG_OUT !== 9'h1FF)
            $display("FAIL ledg_width: got rd=%h ledg=%h want 000001ff/1ff", d, LEDG_OUT);
        else passed++;
    endtask

    task automatic test_hex_reserved();
        logic [31:0] d;
        ahb_write(32'h08, 32'h0012_3456);
        total++; if (HEX_OUT !== 24'h123456) $display("FAIL hex_out: got %h want 123456", HEX_OUT); else passed++;
        ahb_read(32'h08, d);
        total++; if (d !== 32'h0012_3456) $display("FAIL hex_read: got %h want 00123456", d); else passed++;
        ahb_read(32'h1C, d);
        total++; if (d !== 32'h0) $display("FAIL rsvd_1c_read: got %h want 0", d); else passed++;
        ahb_read(32'h18, d);
        total++; if (d !== 32'h0) $display("FAIL rsvd_18_read: got %h want 0", d); else passed++;
        ahb_write(32'h1C, 32'hFFFF_FFFF);
        total++; if (LEDR_OUT !== 18'h3FFFF || LEDG_OUT !== 9'h1FF || HEX_OUT !== 24'h123456)
            $display("FAIL rsvd_write: got ledr=%h ledg=%h hex=%h want 3ffff/1ff/123456", LEDR_OUT, LEDG_OUT, HEX_OUT);
        else passed++;
    endtask

    task automatic test_switches();
        logic [31:0] d;
        SW_IN = 10'h2A5;
        wait_cycles(20);
        ahb_read(32'h0C, d);
        total++; if (d !== 32'h0000_02A5) $display("FAIL sw_read: got %h want 000002a5", d); else passed++;
`ifdef BOARD_IO_DEBOUNCE_EN
        SW_IN[0] = 1'b0;
        wait_cycles(5);
        SW_IN[0] = 1'b1;
        ahb_read(32'h0C, d);
        total++; if (d !== 32'h0000_02A5) $display("FAIL sw_glitch_during: got %h want 000002a5", d); else passed++;
        wait_cycles(20);
        ahb_read(32'h0C, d);
        total++; if (d !== 32'h0000_02A5) $display("FAIL sw_glitch_after: got %h want 000002a5", d); else passed++;
`endif
    endtask

    task automatic test_keys();
        logic [31:0] d;
        KEY_N_IN[2] = 1'b0;
        wait_cycles(20);
        ahb_read(32'h10, d);
        total++; if (d !== 32'h4) $display("FAIL key_pressed: got %h want 4", d); else passed++;
        ahb_read(32'h14, d);
        total++; if (d !== 32'h4) $display("FAIL key_edge_set: got %h want 4", d); else passed++;
        KEY_N_IN[2] = 1'b1;
        wait_cycles(20);
        ahb_read(32'h10, d);
        total++; if (d !== 32'h0) $display("FAIL key_released: got %h want 0", d); else passed++;
        ahb_read(32'h14, d);
        total++; if (d !== 32'h4) $display("FAIL key_edge_sticky: got %h want 4", d); else passed++;
        ahb_write(32'h14, 32'h4);
        ahb_read(32'h14, d);
        total++; if (d !== 32'h0) $display("FAIL key_edge_w1c: got %h want 0", d); else passed++;
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        KEY_N_IN[1] = 1'b0;
        wait_cycles(LAT - 2);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h14;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = 32'h2;
        @(posedge HCLK); #1;
        ahb_read(32'h14, d);
        total++; if (d !== 32'h2) $display("FAIL w1c_race_set_wins: got %h want 2", d); else passed++;
        ahb_write(32'h14, 32'h2);
        ahb_read(32'h14, d);
        total++; if (d !== 32'h0) $display("FAIL w1c_race_later_clear: got %h want 0", d); else passed++;
        KEY_N_IN[1] = 1'b1;
        wait_cycles(20);
    endtask

    task automatic test_idle_and_reset_mid_write();
        logic [31:0] d;
        ahb_write(32'h00, 32'h15);
        HSEL = 1'b1; HTRANS = HTRANS_IDLE; HWRITE = 1'b1; HADDR = 32'h00;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = 32'h2A;
        @(posedge HCLK); #1;
        total++; if (LEDR_OUT !== 18'h15) $display("FAIL idle_no_write: got %h want 15", LEDR_OUT); else passed++;

        KEY_N_IN[3] = 1'b0;
        wait_cycles(20);
        ahb_write(32'h14, 32'h8);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h04;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = 32'h155;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        total++; if (LEDG_OUT !== 9'h0 || LEDR_OUT !== 18'h0) $display("FAIL reset_mid_write: got ledg=%h ledr=%h want 0/0", LEDG_OUT, LEDR_OUT); else passed++;
        @(posedge HCLK); #1;
        total++; if (LEDG_OUT !== 9'h0) $display("FAIL reset_write_lost: got %h want 0", LEDG_OUT); else passed++;
        wait_cycles(20);
        ahb_read(32'h14, d);
        total++; if (d !== 32'h8) $display("FAIL held_press_edge: got %h want 8", d); else passed++;
        KEY_N_IN[3] = 1'b1;
        wait_cycles(20);
    endtask

    initial begin
        HRESET   = 1'b1;
        HSIZE    = 3'b010;
        HREADY   = 1'b1;
        HWDATA   = 32'h0;
        SW_IN    = 10'h0;
        KEY_N_IN = 4'hF;
        bus_idle();
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        test_reset();
        test_back_to_back();
        test_hex_reserved();
        test_switches();
        test_keys();
        test_w1c_race();
        test_idle_and_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
